// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue. FETCH_ALIGN_CHECK_EN adds a per-entry
// misalign flag so misaligned PCs travel through the queue as NOPs.
package fetch_pkg;

    localparam int unsigned FetchAddrWidth = 32;
    localparam int unsigned FetchDataWidth = 32;

    localparam logic [FetchDataWidth-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
`ifdef FETCH_ALIGN_CHECK_EN
        logic                      misalign;
`endif
        logic [FetchAddrWidth-1:0] pc;
        logic [FetchDataWidth-1:0] instr;
    } fetch_entry_t;

    function automatic logic fetch_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetch_entry_t; clear empties it in one cycle and wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_push  = push_i && !clear_i && (count_q != FullCount);
        do_pop   = pop_i && !clear_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue between PC stage and decode: one-cycle ROM reads buffered in fetch_fifo.
// FETCH_ALIGN_CHECK_EN adds misalign_o; entry widths follow fetch_pkg.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FetchAddrWidth,
    parameter int unsigned DATA_WIDTH = FetchDataWidth,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pc_valid_i,
    input  logic [ADDR_WIDTH-1:0]  pc_i,
    output logic                   pc_ready_o,
    input  logic                   flush_i,
    output logic                   mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
    output logic                   instr_valid_o,
    output logic [DATA_WIDTH-1:0]  instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    input  logic                   instr_ready_i,
    output logic [$clog2(DEPTH):0] occupancy_o
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                   misalign_o
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW:0] DepthCredits = (CntW + 1)'(DEPTH);

    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [CntW-1:0]       count;
    logic [CntW:0]         credits;
    logic                  accept;
    logic                  fifo_push, fifo_pop;
    fetch_entry_t          push_entry, head;

`ifdef FETCH_ALIGN_CHECK_EN
    logic inflight_mis_q, inflight_mis_d;
`endif

    always_comb begin
        // Reserve a slot for the in-flight read so its response can never meet a full FIFO.
        credits    = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
        pc_ready_o = !rst_i && !flush_i && (credits < DepthCredits);
        accept     = pc_valid_i && pc_ready_o;
`ifdef FETCH_ALIGN_CHECK_EN
        mem_rd_en_o    = accept && !fetch_misaligned(pc_i[1:0]);
        inflight_mis_d = accept ? fetch_misaligned(pc_i[1:0]) : inflight_mis_q;
`else
        mem_rd_en_o    = accept;
`endif
        // Flush forces pc_ready low, so the in-flight slot drains on the flush edge.
        inflight_d    = accept;
        inflight_pc_d = accept ? pc_i : inflight_pc_q;

        fifo_push        = inflight_q && !flush_i;
        push_entry       = '0;
        push_entry.pc    = inflight_pc_q;
        push_entry.instr = mem_rdata_i;
`ifdef FETCH_ALIGN_CHECK_EN
        push_entry.misalign = inflight_mis_q;
        if (inflight_mis_q) push_entry.instr = NOP_INSTR;
`endif
        fifo_pop = (count != '0) && instr_ready_i && !flush_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            inflight_mis_q <= 1'b0;
`endif
        end else begin
            inflight_q     <= inflight_d;
            inflight_pc_q  <= inflight_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
            inflight_mis_q <= inflight_mis_d;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .clear_i     (flush_i),
        .head_o      (head),
        .count_o     (count)
    );

    assign mem_addr_o    = pc_i;
    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? head.instr : '0;
    assign instr_pc_o    = instr_valid_o ? head.pc : '0;
    assign occupancy_o   = count;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_o    = instr_valid_o && head.misalign;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: queue-based reference model checked every cycle,
// plus literal expectations at key points. Define FETCH_ALIGN_CHECK_EN to test misalign.
module tb_instr_fetch_queue;

    localparam int Depth = 4;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit AlignEn = 1'b1;
`else
    localparam bit AlignEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [2:0]  occupancy;
    logic [31:0] rom_q;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (Depth)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_valid_i    (pc_valid),
        .pc_i          (pc),
        .pc_ready_o    (pc_ready),
        .flush_i       (flush),
        .mem_rd_en_o   (mem_rd_en),
        .mem_addr_o    (mem_addr),
        .mem_rdata_i   (mem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready),
        .occupancy_o   (occupancy)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_o    (misalign)
`endif
    );

    // Synchronous ROM, ROM[a] = a + 0x100; junk when no read was issued.
    always @(posedge clk) rom_q <= mem_rd_en ? mem_addr + 32'h100 : 32'hDEAD_BEEF;
    assign mem_rdata = rom_q;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          mis;
    } ent_t;

    ent_t        mq[$];
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;
    bit          m_infl_mis = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pc_mis(input logic [31:0] a);
        return AlignEn && (a[1:0] != 2'b00);
    endfunction

    task automatic compare_outputs();
        bit exp_ready;
        bit exp_rd;
        exp_ready = !rst && !flush && ((mq.size() + int'(m_infl)) < Depth);
        exp_rd    = pc_valid && exp_ready && !pc_mis(pc);
        check("pc_ready", 64'(pc_ready), 64'(exp_ready));
        check("mem_rd_en", 64'(mem_rd_en), 64'(exp_rd));
        if (exp_rd) check("mem_addr", 64'(mem_addr), 64'(pc));
        check("instr_valid", 64'(instr_valid), 64'(mq.size() != 0));
        check("occupancy", 64'(occupancy), 64'(mq.size()));
        if (mq.size() != 0) begin
            check("instr", 64'(instr), 64'(mq[0].instr));
            check("instr_pc", 64'(instr_pc), 64'(mq[0].pc));
`ifdef FETCH_ALIGN_CHECK_EN
            check("misalign", 64'(misalign), 64'(mq[0].mis));
`endif
        end
        if (rst) begin
            check("rst_instr", 64'(instr), 64'(0));
            check("rst_instr_pc", 64'(instr_pc), 64'(0));
        end
    endtask

    // Reference behaviour at a clock edge, from the values held before the edge.
    task automatic model_edge();
        bit   rdy;
        bit   acc;
        ent_t e;
        if (rst || flush) begin
            mq.delete();
            m_infl = 1'b0;
        end else begin
            rdy = (mq.size() + int'(m_infl)) < Depth;
            acc = pc_valid && rdy;
            if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
            if (m_infl) begin
                e.pc    = m_infl_pc;
                e.instr = m_infl_mis ? 32'h0000_0013 : m_infl_pc + 32'h100;
                e.mis   = m_infl_mis;
                mq.push_back(e);
            end
            m_infl = acc;
            if (acc) begin
                m_infl_pc  = pc;
                m_infl_mis = pc_mis(pc);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input bit rdy);
        pc_valid    = v;
        pc          = a;
        instr_ready = rdy;
    endtask

    initial begin
        repeat (2) tick();
        check("lit_reset_valid", 64'(instr_valid), 64'(0));
        check("lit_reset_occ", 64'(occupancy), 64'(0));
        check("lit_reset_ready", 64'(pc_ready), 64'(0));
        rst = 1'b0;
        tick();

        // Back-to-back stream 0,4,8,12 with decode always ready.
        drive(1, 32'h0, 1);
        tick();
        check("lit_stream_lat1", 64'(instr_valid), 64'(0));
        drive(1, 32'h4, 1);
        tick();
        check("lit_stream_v0", 64'(instr_valid), 64'(1));
        check("lit_stream_i0", 64'(instr), 64'(32'h100));
        check("lit_stream_pc0", 64'(instr_pc), 64'(32'h0));
        drive(1, 32'h8, 1);
        tick();
        check("lit_stream_i1", 64'(instr), 64'(32'h104));
        drive(1, 32'hC, 1);
        tick();
        check("lit_stream_i2", 64'(instr), 64'(32'h108));
        drive(0, 32'h0, 1);
        tick();
        check("lit_stream_i3", 64'(instr), 64'(32'h10C));
        check("lit_stream_pc3", 64'(instr_pc), 64'(32'hC));
        tick();
        check("lit_stream_empty", 64'(instr_valid), 64'(0));

        // Backpressure: four accepts fill the queue, one pop reopens pc_ready.
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h20 + 32'(4 * i), 0);
            tick();
        end
        check("lit_bp_occ", 64'(occupancy), 64'(4));
        check("lit_bp_ready", 64'(pc_ready), 64'(0));
        check("lit_bp_head", 64'(instr_pc), 64'(32'h20));
        drive(1, 32'h40, 1);
        tick();
        drive(0, 32'h0, 0);
        check("lit_bp_reopen", 64'(pc_ready), 64'(1));
        check("lit_bp_head2", 64'(instr), 64'(32'h124));
        drive(0, 32'h0, 1);
        repeat (4) tick();

        // Flush with two queued entries and one read in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h30 + 32'(4 * i), 0);
            tick();
        end
        check("lit_fl_occ", 64'(occupancy), 64'(2));
        flush = 1'b1;
        drive(1, 32'h3C, 1);
        tick();
        flush = 1'b0;
        check("lit_fl_occ0", 64'(occupancy), 64'(0));
        check("lit_fl_valid0", 64'(instr_valid), 64'(0));
        drive(1, 32'h40, 0);
        tick();
        drive(0, 32'h0, 0);
        tick();
        check("lit_fl_next_pc", 64'(instr_pc), 64'(32'h40));
        check("lit_fl_next_i", 64'(instr), 64'(32'h140));
        check("lit_fl_next_occ", 64'(occupancy), 64'(1));
        drive(0, 32'h0, 1);
        tick();

        // Simultaneous push and pop at occupancy 2.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h50 + 32'(4 * i), 0);
            tick();
        end
        drive(0, 32'h0, 1);
        tick();
        check("lit_pp_occ", 64'(occupancy), 64'(2));
        check("lit_pp_head", 64'(instr_pc), 64'(32'h54));
        repeat (2) tick();

        // Ten fetches with intermittent backpressure wrap the pointers.
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h200 + 32'(4 * i), (i % 3) != 0);
            tick();
        end
        drive(0, 32'h0, 1);
        repeat (6) tick();
        check("lit_wrap_empty", 64'(instr_valid), 64'(0));

`ifdef FETCH_ALIGN_CHECK_EN
        drive(1, 32'h6, 0);
        tick();
        drive(0, 32'h0, 0);
        tick();
        check("lit_mis_valid", 64'(instr_valid), 64'(1));
        check("lit_mis_instr", 64'(instr), 64'(32'h13));
        check("lit_mis_pc", 64'(instr_pc), 64'(32'h6));
        check("lit_mis_flag", 64'(misalign), 64'(1));
        drive(0, 32'h0, 1);
        tick();
`endif

        // Asynchronous reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h60 + 32'(4 * i), 0);
            tick();
        end
        drive(0, 32'h0, 0);
        tick();
        check("lit_rst_pre_occ", 64'(occupancy), 64'(3));
        rst = 1'b1;
        mq.delete();
        m_infl = 1'b0;
        #1;
        check("lit_rst_valid", 64'(instr_valid), 64'(0));
        check("lit_rst_occ", 64'(occupancy), 64'(0));
        check("lit_rst_ready", 64'(pc_ready), 64'(0));
        check("lit_rst_instr", 64'(instr), 64'(0));
        drive(1, 32'h70, 1);
        repeat (2) tick();
        rst = 1'b0;
        drive(0, 32'h0, 1);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
